// File: rtl/pattern_tone_player.sv
// Pattern sequencer: plays a captured bit pattern LSB-first, one symbol per
// tick period, on LED, and gates a square-wave tone with the current symbol.
// Supports one-shot or looped playback with an optional silent gap between
// repeats, loaded through a valid/ready handshake.
module pattern_tone_player #(
  parameter int MESSAGE_WIDTH = 78,
  parameter int TICK_WIDTH    = 32,
  parameter int TONE_WIDTH    = 24,
  parameter int GAP_TICKS     = 0,
  parameter int IDX_W         = $clog2(MESSAGE_WIDTH),
  parameter int LEN_W         = $clog2(MESSAGE_WIDTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [MESSAGE_WIDTH-1:0] pattern_in,
  input  logic [LEN_W-1:0]         length_in,
  input  logic [TICK_WIDTH-1:0]    tick_rate_in,
  input  logic [TONE_WIDTH-1:0]    tone_half_period_in,
  input  logic                     loop_in,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     stop,
  output logic                     LED,
  output logic                     tone_out,
  output logic                     START,
  output logic                     done,
  output logic                     busy,
  output logic [IDX_W-1:0]         blink_index
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         idx, idx_n, idx_inc;
  logic [TICK_WIDTH-1:0]    tick_cnt, tick_n;
  logic [31:0]              gap_cnt, gap_n;
  logic [TONE_WIDTH-1:0]    tone_cnt, tone_n;
  logic                     phase, phase_n;
  logic [MESSAGE_WIDTH-1:0] pat_r, pat_n;
  logic [LEN_W-1:0]         len_r, len_n;
  logic [TICK_WIDTH-1:0]    rate_r, rate_n;
  logic [TONE_WIDTH-1:0]    half_r, half_n;
  logic                     loop_r, loop_n;
  logic                     led_r, led_n;
  logic                     start_r, start_n;
  logic                     done_r, done_n;
  logic                     accept, tick_last, sym_last, gap_last;

  assign load_ready  = (state == S_IDLE) && !RST;
  assign busy        = (state != S_IDLE);
  assign accept      = load_valid && load_ready;
  assign LED         = led_r;
  assign START       = start_r;
  assign done        = done_r;
  assign blink_index = idx;
  assign tone_out    = led_r & phase & (half_r != '0);

  assign idx_inc   = idx + IDX_W'(1);
  assign tick_last = (tick_cnt == rate_r - TICK_WIDTH'(1));
  assign sym_last  = (LEN_W'(idx) == len_r - LEN_W'(1));
  assign gap_last  = (gap_cnt == 32'(GAP_TICKS - 1));

  // State and datapath registers; everything clears asynchronously on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
      pat_r    <= '0;
      len_r    <= '0;
      rate_r   <= '0;
      half_r   <= '0;
      loop_r   <= 1'b0;
      led_r    <= 1'b0;
      start_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tick_cnt <= tick_n;
      gap_cnt  <= gap_n;
      tone_cnt <= tone_n;
      phase    <= phase_n;
      pat_r    <= pat_n;
      len_r    <= len_n;
      rate_r   <= rate_n;
      half_r   <= half_n;
      loop_r   <= loop_n;
      led_r    <= led_n;
      start_r  <= start_n;
      done_r   <= done_n;
    end
  end

  // Next-state, counter and registered-output decode.
  // LED/START/done are computed one cycle ahead so they appear registered
  // in the same cycle as the state/index they describe.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tick_n  = tick_cnt;
    gap_n   = gap_cnt;
    tone_n  = tone_cnt;
    phase_n = phase;
    pat_n   = pat_r;
    len_n   = len_r;
    rate_n  = rate_r;
    half_n  = half_r;
    loop_n  = loop_r;
    led_n   = led_r;
    start_n = 1'b0;
    done_n  = 1'b0;

    // Tone runs free across symbols and loop wraps while busy.
    if (state != S_IDLE && half_r != '0) begin
      if (tone_cnt == half_r - TONE_WIDTH'(1)) begin
        tone_n  = '0;
        phase_n = ~phase;
      end else begin
        tone_n = tone_cnt + TONE_WIDTH'(1);
      end
    end

    case (state)
      S_IDLE: begin
        led_n = 1'b0;
        if (accept) begin
          pat_n = pattern_in;
          if (length_in == '0 || length_in > LEN_W'(MESSAGE_WIDTH))
            len_n = LEN_W'(MESSAGE_WIDTH);
          else
            len_n = length_in;
          rate_n  = (tick_rate_in == '0) ? TICK_WIDTH'(1) : tick_rate_in;
          half_n  = tone_half_period_in;
          loop_n  = loop_in;
          state_n = S_PLAY;
          idx_n   = '0;
          tick_n  = '0;
          gap_n   = '0;
          tone_n  = '0;
          phase_n = 1'b0;
          led_n   = pattern_in[0];
          start_n = 1'b1;
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_n = S_IDLE;
          led_n   = 1'b0;
          done_n  = 1'b1;
        end else if (tick_last) begin
          tick_n = '0;
          if (!sym_last) begin
            idx_n = idx_inc;
            led_n = pat_r[idx_inc];
          end else if (!loop_r) begin
            state_n = S_IDLE;
            led_n   = 1'b0;
            done_n  = 1'b1;
          end else if (GAP_TICKS == 0) begin
            idx_n   = '0;
            led_n   = pat_r[0];
            start_n = 1'b1;
          end else begin
            state_n = S_GAP;
            gap_n   = '0;
            led_n   = 1'b0;
          end
        end else begin
          tick_n = tick_cnt + TICK_WIDTH'(1);
        end
      end

      S_GAP: begin
        if (stop) begin
          state_n = S_IDLE;
          led_n   = 1'b0;
          done_n  = 1'b1;
        end else if (tick_last) begin
          tick_n = '0;
          if (gap_last) begin
            state_n = S_PLAY;
            idx_n   = '0;
            led_n   = pat_r[0];
            start_n = 1'b1;
          end else begin
            gap_n = gap_cnt + 32'd1;
          end
        end else begin
          tick_n = tick_cnt + TICK_WIDTH'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
        led_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_tone_player.sv
// Bench for pattern_tone_player: directed loads push per-cycle expectations
// into a cycle-ordered scoreboard; a negedge monitor pops and compares them.
module tb_pattern_tone_player;

  localparam int MW = 78;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [MW-1:0] pattern_in = '0;
  logic [6:0]    length_in = '0;
  logic [31:0]   tick_rate_in = '0;
  logic [23:0]   tone_half_period_in = '0;
  logic          loop_in = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          stop = 1'b0;
  logic          LED, tone_out, START, done, busy;
  logic [6:0]    blink_index;

  pattern_tone_player #(.MESSAGE_WIDTH(MW), .GAP_TICKS(2)) dut (
    .CLK(CLK), .RST(RST), .pattern_in(pattern_in), .length_in(length_in),
    .tick_rate_in(tick_rate_in), .tone_half_period_in(tone_half_period_in),
    .loop_in(loop_in), .load_valid(load_valid), .load_ready(load_ready),
    .stop(stop), .LED(LED), .tone_out(tone_out), .START(START), .done(done),
    .busy(busy), .blink_index(blink_index)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int S_LED = 0, S_TONE = 1, S_START = 2, S_DONE = 3,
                 S_BUSY = 4, S_IDX = 5, S_RDY = 6;
  string sname [7] = '{"LED", "tone_out", "START", "done", "busy", "blink_index", "load_ready"};

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sbq [$];
  int   tests = 0;
  int   fails = 0;
  int   base  = 0;

  function automatic int sample(int sig);
    case (sig)
      S_LED:   return int'(LED);
      S_TONE:  return int'(tone_out);
      S_START: return int'(START);
      S_DONE:  return int'(done);
      S_BUSY:  return int'(busy);
      S_IDX:   return int'(blink_index);
      S_RDY:   return int'(load_ready);
      default: return -1;
    endcase
  endfunction

  // Keep the queue ordered by cycle so the monitor can pop from the front.
  task automatic push(int k, int sig, int val, string tag);
    exp_t e;
    int   pos;
    e.cyc = base + k;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    pos = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].cyc > e.cyc) begin
        pos = i;
        break;
      end
    end
    sbq.insert(pos, e);
  endtask

  // Monitor: compares every expectation due at this cycle.
  exp_t me;
  int   mact;
  always @(negedge CLK) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me   = sbq.pop_front();
      mact = sample(me.sig);
      tests++;
      if (me.cyc != cyc) begin
        fails++;
        $display("FAIL %s %s: expectation for cycle %0d missed (now %0d)",
                 me.tag, sname[me.sig], me.cyc, cyc);
      end else if (mact != me.val) begin
        fails++;
        $display("FAIL %s %s @cyc %0d: got %0d, expected %0d",
                 me.tag, sname[me.sig], cyc - base, mact, me.val);
      end
    end
  end

  // Advance to the negedge of relative cycle k.
  task automatic goto(int k);
    do @(negedge CLK); while (cyc < base + k);
  endtask

  // Must be called at a negedge; that cycle becomes relative cycle 0.
  task automatic run_load(logic [MW-1:0] p, int len, int rate, int half,
                          bit lp, bit with_stop);
    pattern_in          = p;
    length_in           = 7'(len);
    tick_rate_in        = 32'(rate);
    tone_half_period_in = 24'(half);
    loop_in             = lp;
    stop                = with_stop;
    load_valid          = 1'b1;
    base                = cyc;
    @(posedge CLK);
    #1;
    load_valid = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge CLK);
    #1;
    stop = 1'b0;
  endtask

  logic [MW-1:0] npat;
  logic [MW-1:0] ones;

  initial begin
    ones = '1;

    // Reset values while RST is held.
    base = 0;
    for (int k = 2; k <= 3; k++) begin
      push(k, S_LED, 0, "reset");
      push(k, S_TONE, 0, "reset");
      push(k, S_START, 0, "reset");
      push(k, S_DONE, 0, "reset");
      push(k, S_BUSY, 0, "reset");
      push(k, S_IDX, 0, "reset");
      push(k, S_RDY, 0, "reset");
    end
    push(5, S_RDY, 1, "reset_release");
    push(5, S_BUSY, 0, "reset_release");
    goto(4);
    #1 RST = 1'b0;
    goto(6);

    // One-shot 1010, len 4, rate 3; an extra load during PLAY is ignored.
    run_load(MW'(4'b1010), 4, 3, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      push(k, S_LED, ((k >= 4 && k <= 6) || (k >= 10 && k <= 12)) ? 1 : 0, "oneshot");
      push(k, S_BUSY, (k <= 12) ? 1 : 0, "oneshot");
      push(k, S_DONE, (k == 13) ? 1 : 0, "oneshot");
      push(k, S_START, (k == 1) ? 1 : 0, "oneshot");
      push(k, S_RDY, (k == 13) ? 1 : 0, "oneshot");
      if (k <= 12) push(k, S_IDX, (k - 1) / 3, "oneshot");
    end
    goto(5);
    pattern_in = ones;
    length_in  = 7'd1;
    load_valid = 1'b1;
    @(posedge CLK);
    #1 load_valid = 1'b0;
    goto(13);

    // Back-to-back load in the done cycle, then stop at cycle 5.
    run_load(MW'(4'b0110), 4, 3, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      push(k, S_LED, (k == 4 || k == 5) ? 1 : 0, "stop");
      push(k, S_BUSY, (k <= 5) ? 1 : 0, "stop");
      push(k, S_DONE, (k == 6) ? 1 : 0, "stop");
      push(k, S_START, (k == 1) ? 1 : 0, "stop");
      if (k <= 5) push(k, S_IDX, (k - 1) / 3, "stop");
    end
    goto(5);
    pulse_stop();
    goto(8);

    // Stop coinciding with a load in IDLE: the load wins.
    run_load(MW'(2'b11), 2, 1, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      push(k, S_LED, (k <= 2) ? 1 : 0, "stop_load");
      push(k, S_BUSY, (k <= 2) ? 1 : 0, "stop_load");
      push(k, S_DONE, (k == 3) ? 1 : 0, "stop_load");
      push(k, S_START, (k == 1) ? 1 : 0, "stop_load");
    end
    goto(4);

    // Loop with a 2-tick gap: len 3, rate 2, all ones.
    run_load(ones, 3, 2, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      bit g;
      g = (k >= 7 && k <= 10) || (k >= 17 && k <= 20);
      push(k, S_DONE, (k == 23) ? 1 : 0, "loopgap");
      push(k, S_BUSY, (k <= 22) ? 1 : 0, "loopgap");
      push(k, S_LED, (k <= 22 && !g) ? 1 : 0, "loopgap");
      if (k <= 22) begin
        push(k, S_START, (k == 1 || k == 11 || k == 21) ? 1 : 0, "loopgap");
        push(k, S_IDX, g ? 2 : ((k - 1) % 10) / 2, "loopgap");
      end
    end
    goto(22);
    pulse_stop();
    goto(24);

    // Tone half period 4 over a long symbol.
    run_load(ones, 1, 100, 4, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++)
      push(k, S_TONE, (k <= 24) ? ((k - 1) / 4) % 2 : 0, "tone");
    push(25, S_DONE, 1, "tone");
    goto(24);
    pulse_stop();
    goto(26);

    // Half period 0 keeps the tone silent while LED is on.
    run_load(ones, 1, 100, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      push(k, S_TONE, 0, "tone_off");
      push(k, S_LED, 1, "tone_off");
    end
    goto(20);
    pulse_stop();
    goto(23);

    // length 0 and rate 0 normalise to MW symbols of one cycle each.
    npat = '0;
    for (int i = 0; i < MW; i++) npat[i] = (i % 3 == 0);
    npat[MW-1] = 1'b1;
    run_load(npat, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= MW + 1; k++) begin
      if (k <= MW) begin
        push(k, S_IDX, k - 1, "norm");
        push(k, S_LED, int'(npat[k-1]), "norm");
      end
      push(k, S_BUSY, (k <= MW) ? 1 : 0, "norm");
      push(k, S_DONE, (k == MW + 1) ? 1 : 0, "norm");
    end
    goto(MW + 2);

    // Asynchronous reset mid-play, then a fresh load.
    run_load(ones, 4, 3, 2, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      push(k, S_LED, 1, "rst_mid");
      push(k, S_BUSY, 1, "rst_mid");
    end
    push(7, S_LED, 0, "rst_mid");
    push(7, S_TONE, 0, "rst_mid");
    push(7, S_START, 0, "rst_mid");
    push(7, S_DONE, 0, "rst_mid");
    push(7, S_BUSY, 0, "rst_mid");
    push(7, S_IDX, 0, "rst_mid");
    push(7, S_RDY, 0, "rst_mid");
    push(8, S_DONE, 0, "rst_mid");
    push(8, S_RDY, 0, "rst_mid");
    push(9, S_DONE, 0, "rst_mid");
    push(9, S_RDY, 1, "rst_mid");
    goto(6);
    @(posedge CLK);
    #1 RST = 1'b1;
    goto(8);
    #1 RST = 1'b0;
    goto(9);

    run_load(MW'(4'b0011), 4, 1, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      push(k, S_LED, (k <= 2) ? 1 : 0, "after_rst");
      push(k, S_START, (k == 1) ? 1 : 0, "after_rst");
      push(k, S_BUSY, (k <= 4) ? 1 : 0, "after_rst");
      push(k, S_DONE, (k == 5) ? 1 : 0, "after_rst");
    end
    goto(6);

    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge CLK);
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_tone_player.md
# pattern_tone_player

Parametrised pattern sequencer with a gated tone output. It plays a loaded bit pattern LSB-first, one symbol per programmable tick period, on `LED`, and gates a programmable square-wave tone with the current symbol. It supports one-shot or looped playback with an optional inter-repeat gap, and a valid/ready load handshake. It sits between pattern-producing logic (or constants in `top`) and the board LED and speaker pins.

## Interface
- `MESSAGE_WIDTH`, 78: maximum pattern length in symbols.
- `TICK_WIDTH`, 32: width of the tick-rate counter and input.
- `TONE_WIDTH`, 24: width of the tone half-period counter and input.
- `GAP_TICKS`, 0: silent symbol periods inserted between loop repeats.
- Derived: `IDX_W = $clog2(MESSAGE_WIDTH)`, `LEN_W = $clog2(MESSAGE_WIDTH+1)`.

Ports:
- `CLK` in 1: system clock (16 MHz on the BX board).
- `RST` in 1: asynchronous, active-high reset.
- `pattern_in` in MESSAGE_WIDTH: symbols; bit 0 plays first.
- `length_in` in LEN_W: symbols to play; 0 means MESSAGE_WIDTH; values above MESSAGE_WIDTH clamp to MESSAGE_WIDTH.
- `tick_rate_in` in TICK_WIDTH: CLK cycles per symbol; 0 is treated as 1.
- `tone_half_period_in` in TONE_WIDTH: CLK cycles per tone half-wave; 0 disables the tone.
- `loop_in` in 1: 1 = repeat forever, 0 = one-shot.
- `load_valid` in 1: load request.
- `load_ready` out 1: high only in IDLE.
- `stop` in 1: abort playback.
- `LED` out 1: current symbol; 0 when not playing.
- `tone_out` out 1: `LED` AND tone square wave.
- `START` out 1: one-cycle pulse on entry to symbol 0.
- `done` out 1: one-cycle pulse on return to IDLE from playback.
- `busy` out 1: high in PLAY or GAP.
- `blink_index` out IDX_W: current symbol index.

## Operation
- **States:** IDLE, PLAY, GAP.
- **Load:** a load is accepted when `load_valid && load_ready`. On acceptance, `pattern_in`, `length_in`, `tick_rate_in`, `tone_half_period_in` and `loop_in` are captured into shadow registers after the 0/clamp normalisation. Later input changes have no effect until the next load.
- **IDLE → PLAY on accept:**
  - `blink_index`=0, tick count=0, tone count=0, tone phase=0.
  - `START` is high for the first PLAY cycle.
- **PLAY:**
  - `LED` = pattern[`blink_index`].
  - The tick counter counts 0..rate-1. At rate-1, if `blink_index` < len-1, it increments `blink_index` and clears the tick counter.
- **End of the last symbol (`blink_index`=len-1, tick=rate-1):**
  - loop=0: → IDLE, `done`=1 for one cycle.
  - loop=1, GAP_TICKS=0: `blink_index`←0, stay in PLAY, `START` pulses.
  - loop=1, GAP_TICKS>0: → GAP.
- **GAP:**
  - `LED`=0, `blink_index` holds len-1.
  - Lasts GAP_TICKS×rate cycles, then → PLAY with `blink_index`=0, `START` pulse, tick count=0.
- **Tone:**
  - The tone counter runs only in PLAY/GAP, counting 0..half-1. At half-1 it wraps and toggles the phase.
  - `tone_out` = `LED` & phase.
  - half=0: `tone_out` is held at 0.
  - The tone counter and phase are not reset at symbol boundaries or loop wraps; they reset only on load.
- **Stop:**
  - `stop` in PLAY/GAP → IDLE next cycle, `done`=1 for one cycle, regardless of the end-of-pattern condition that same cycle.
  - `stop` in IDLE is ignored, including when it coincides with a load; the load is accepted.
- **Load while busy:** not possible (`load_ready`=0); the request is ignored and nothing is queued.

## Timing
- **Reset:** state=IDLE. `LED`, `tone_out`, `START`, `done`, `busy`=0; `blink_index`=0; all counters and shadow registers 0. `load_ready` is forced to 0 while `RST` is high, and loads are ignored.
- **Reset mid-playback:** all outputs are at reset values immediately (asynchronous), with no `done` pulse. The block is ready for a load on the first cycle after `RST` falls.
- **Outputs:** all outputs are registered except `load_ready`, `busy` and `tone_out`, which are decoded from registered state only.
- **Latency:** load accept edge → `LED` valid on the next cycle. Each symbol lasts exactly rate cycles. A one-shot pattern is busy for len×rate cycles, and `done` is asserted in the following cycle.
- **Back-to-back loads:** a new load may be accepted in the cycle `done` is high, because `load_ready`=1 in IDLE.

## Test plan
- **One-shot:** `pattern_in`=4'b1010, len 4, rate 3, loop 0, accept at cycle 0 → `LED` is 0 for cycles 1-3, 1 for 4-6, 0 for 7-9, 1 for 10-12; `busy` is high for cycles 1-12; `done` is high only at cycle 13; `START` is high only at cycle 1.
- **Loop with gap:** GAP_TICKS=2, len 3, rate 2, all-ones pattern → `START` at cycles 1, 11, 21; `LED`=0 during cycles 7-10; `done` never asserts.
- **Tone:** all-ones pattern, rate 100, half 4 → `tone_out` is low for cycles 1-4 and high for 5-8, with period 8. A second load with half=0 → `tone_out` stays 0.
- **Stop:** `stop` at cycle 5 of a rate-3 playback → IDLE at cycle 6 with `done`=1. `stop` together with `load_valid` in IDLE → load accepted. `load_valid` during PLAY → ignored, and playback is unchanged.
- **Normalisation:** `length_in`=0 and `tick_rate_in`=0 → MESSAGE_WIDTH symbols, one cycle each, and `blink_index` reaches MESSAGE_WIDTH-1.
- **Reset mid-play:** `RST` pulsed at cycle 7 → all outputs 0 within that cycle, with no `done` pulse; a load one cycle after `RST` deasserts → normal playback.
